div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared RV32M definitions: opcode/funct encodings and the divider FSM state type.
// Also consumed by the ALU and decoder so encodings stay in one place.
package div_unit_pkg;

  localparam logic [6:0] OPC_R_M  = 7'b0110011;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_START = 2'd1,
    DIV_CALC  = 2'd2,
    DIV_END   = 2'd3
  } div_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider: 32-step restoring shift-subtract with
// short-circuit paths for divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start_i,
  input  logic [31:0] div_op1_i,
  input  logic [31:0] div_op2_i,
  input  logic [2:0]  div_funct3_i,
  input  logic [4:0]  div_wr_reg_addr_i,
  input  logic        div_flush_i,
  output logic        div_stall_o,
  output logic        div_ready_o,
  output logic [31:0] div_result_o,
  output logic        div_wr_reg_en_o,
  output logic [4:0]  div_wr_reg_addr_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        raw_q, raw_d;

  logic        is_signed;
  logic [32:0] partial;
  logic [32:0] diff;
  logic        neg_quot, neg_rem;
  logic [31:0] quot_fix, rem_fix;

  assign is_signed = ~f3_q[0];
  assign partial   = {rem_q, quot_q[31]};
  // bit 32 of the difference is the borrow: set when the divisor does not fit
  assign diff      = partial - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    raw_d   = raw_q;
    case (state_q)
      DIV_IDLE: begin
        if (div_start_i && !div_flush_i) begin
          op1_d   = div_op1_i;
          op2_d   = div_op2_i;
          f3_d    = div_funct3_i;
          rd_d    = div_wr_reg_addr_i;
          state_d = DIV_START;
        end
      end
      DIV_START: begin
        if (div_flush_i) begin
          state_d = DIV_IDLE;
        end else if (op2_q == 32'd0) begin
          quot_d  = 32'hFFFF_FFFF;
          rem_d   = op1_q;
          raw_d   = 1'b1;
          state_d = DIV_END;
        end else if (is_signed && op1_q == 32'h8000_0000 && op2_q == 32'hFFFF_FFFF) begin
          quot_d  = 32'h8000_0000;
          rem_d   = 32'd0;
          raw_d   = 1'b1;
          state_d = DIV_END;
        end else begin
          quot_d  = is_signed ? abs32(op1_q) : op1_q;
          dvsr_d  = is_signed ? abs32(op2_q) : op2_q;
          rem_d   = 32'd0;
          cnt_d   = 5'd31;
          raw_d   = 1'b0;
          state_d = DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (div_flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (!diff[32]) begin
            rem_d  = diff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = partial[31:0];
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = DIV_END;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvsr_q  <= '0;
      raw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      raw_q   <= raw_d;
    end
  end

  // short-circuit results are already final and must not be sign-corrected
  assign neg_quot = (f3_q == F3_DIV) && (op1_q[31] ^ op2_q[31]) && !raw_q;
  assign neg_rem  = (f3_q == F3_REM) && op1_q[31] && !raw_q;
  assign quot_fix = neg_quot ? (~quot_q + 32'd1) : quot_q;
  assign rem_fix  = neg_rem  ? (~rem_q + 32'd1)  : rem_q;

  assign div_ready_o       = (state_q == DIV_END) && !div_flush_i && !rst;
  assign div_wr_reg_en_o   = div_ready_o;
  assign div_result_o      = div_ready_o ? (f3_q[1] ? rem_fix : quot_fix) : 32'd0;
  assign div_wr_reg_addr_o = rd_q;
  assign div_stall_o       = !rst && !div_flush_i &&
                             (((state_q == DIV_IDLE) && div_start_i) ||
                              (state_q == DIV_START) || (state_q == DIV_CALC));

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes model results, a monitor pops
// and compares on every ready pulse, including result latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start_i;
  logic [31:0] div_op1_i;
  logic [31:0] div_op2_i;
  logic [2:0]  div_funct3_i;
  logic [4:0]  div_wr_reg_addr_i;
  logic        div_flush_i;
  logic        div_stall_o;
  logic        div_ready_o;
  logic [31:0] div_result_o;
  logic        div_wr_reg_en_o;
  logic [4:0]  div_wr_reg_addr_o;

  div_unit dut (
    .clk               (clk),
    .rst               (rst),
    .div_start_i       (div_start_i),
    .div_op1_i         (div_op1_i),
    .div_op2_i         (div_op2_i),
    .div_funct3_i      (div_funct3_i),
    .div_wr_reg_addr_i (div_wr_reg_addr_i),
    .div_flush_i       (div_flush_i),
    .div_stall_o       (div_stall_o),
    .div_ready_o       (div_ready_o),
    .div_result_o      (div_result_o),
    .div_wr_reg_en_o   (div_wr_reg_en_o),
    .div_wr_reg_addr_o (div_wr_reg_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb_v;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f3[0]) begin
      sa = a;
      sb_v = b;
      q = sa / sb_v;
      r = sa % sb_v;
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // called at a negedge; the following posedge is the start-sampling edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit track);
    exp_t e;
    div_start_i       = 1'b1;
    div_funct3_i      = f3;
    div_op1_i         = a;
    div_op2_i         = b;
    div_wr_reg_addr_i = rd;
    if (track) begin
      e.res       = ref_result(f3, a, b);
      e.rd        = rd;
      e.start_cyc = cyc + 1;
      e.lat       = ref_latency(f3, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    div_start_i  = 1'b0;
    div_op1_i    = $urandom;
    div_op2_i    = $urandom;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 80 && done_cnt == d0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("completion", done_cnt, d0 + 1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int d0;
    @(negedge clk);
    d0 = done_cnt;
    issue(f3, a, b, rd, 1'b1);
    wait_done(d0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (div_ready_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("result", div_result_o, mon_e.res);
          chk("rd", {27'd0, div_wr_reg_addr_o}, {27'd0, mon_e.rd});
          chk("wr_en", {31'd0, div_wr_reg_en_o}, 32'd1);
          chk("latency", cyc - mon_e.start_cyc + 1, mon_e.lat);
          done_cnt++;
        end
      end else begin
        chk("idle_result", div_result_o, 32'd0);
        chk("idle_wr_en", {31'd0, div_wr_reg_en_o}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, div_stall_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, div_ready_o}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, div_wr_reg_en_o}, 32'd0);
    chk({tag, "_result"}, div_result_o, 32'd0);
    chk({tag, "_addr"}, {27'd0, div_wr_reg_addr_o}, 32'd0);
  endtask

  initial begin : driver
    int d0;
    int mode;
    logic [2:0]  f3;
    logic [31:0] a, b;

    rst               = 1'b1;
    div_start_i       = 1'b1;
    div_op1_i         = 32'd20;
    div_op2_i         = 32'd3;
    div_funct3_i      = 3'b100;
    div_wr_reg_addr_i = 5'd9;
    div_flush_i       = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    div_start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b100, 32'h0000_0014, 32'hFFFF_FFFD, 5'd1);
    run_op(3'b110, 32'h0000_0014, 32'hFFFF_FFFD, 5'd2);
    run_op(3'b101, 32'd7, 32'd0, 5'd3);
    run_op(3'b111, 32'd7, 32'd0, 5'd4);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd2, 5'd8);
    run_op(3'b100, 32'd0, 32'd0, 5'd10);

    // flush during CALC cycle 10, restart on the very next cycle
    @(negedge clk);
    issue(3'b100, 32'd100, 32'd7, 5'd11, 1'b0);
    repeat (10) @(negedge clk);
    #1 chk("stall_in_calc", {31'd0, div_stall_o}, 32'd1);
    div_flush_i = 1'b1;
    #1 chk("stall_on_flush", {31'd0, div_stall_o}, 32'd0);
    chk("ready_on_flush", {31'd0, div_ready_o}, 32'd0);
    @(negedge clk);
    div_flush_i = 1'b0;
    d0 = done_cnt;
    issue(3'b111, 32'd1000, 32'd33, 5'd12, 1'b1);
    wait_done(d0);

    // flush wins over start in IDLE
    @(negedge clk);
    div_flush_i = 1'b1;
    div_start_i = 1'b1;
    #1 chk("flush_prio_stall", {31'd0, div_stall_o}, 32'd0);
    @(negedge clk);
    div_start_i = 1'b0;
    div_flush_i = 1'b0;
    #1 chk("flush_prio_idle", {31'd0, div_stall_o}, 32'd0);

    // reset mid-CALC
    @(negedge clk);
    issue(3'b101, 32'hDEAD_BEEF, 32'd13, 5'd13, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    div_start_i = 1'b1;
    #1 chk_all_zero("rst_mid_calc");
    @(negedge clk);
    div_start_i = 1'b0;
    rst = 1'b0;
    run_op(3'b100, 32'hFFFF_FF00, 32'd16, 5'd14);

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(4, 7));
      mode = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = 32'($urandom_range(0, 200)) - 32'd100;
          b = 32'($urandom_range(0, 20)) - 32'd10;
        end
        3: b = 32'($urandom_range(1, 255));
        default: ;
      endcase
      run_op(f3, a, b, 5'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
